// File: rtl/main_memory_responder.sv
// Main-memory responder below the cache controller. It services one block read or write
// at a time, adds a fixed access latency, and reports completion with a one-cycle pulse.
module main_memory_responder #(
  parameter int          DEPTH_LOG2   = 8,
  parameter int          BLOCK_OFFSET = 6,
  parameter int          LATENCY      = 4,
  parameter logic [63:0] DEFAULT_DATA = 64'hDEADBEEFCAFEBABE
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  input  logic        req_write,
  input  logic [31:0] req_addr,
  input  logic [63:0] req_wdata,
  output logic        mm_ready,
  output logic        resp_valid,
  output logic [63:0] resp_rdata,
  output logic        resp_err,
  output logic [1:0]  state_out
);

  localparam int DEPTH   = 1 << DEPTH_LOG2;
  localparam int IDX_TOP = BLOCK_OFFSET + DEPTH_LOG2;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_WAIT = 2'd1;
  localparam logic [1:0] S_RESP = 2'd2;

  logic [1:0]            state_q, state_d;
  logic [3:0]            cnt_q, cnt_d;
  logic                  write_q;
  logic                  oor_q;
  logic [DEPTH_LOG2-1:0] idx_q;
  logic [63:0]           wdata_q;
  logic [63:0]           rdata_q;
  logic                  err_q;
  logic [DEPTH-1:0]      written_q;
  logic [63:0]           mem [DEPTH];

  logic [DEPTH_LOG2-1:0] req_idx;
  logic                  req_oor;
  logic                  accept;
  logic                  commit;
  logic                  unused_addr_bits;

  assign req_idx          = req_addr[IDX_TOP-1:BLOCK_OFFSET];
  assign req_oor          = |req_addr[31:IDX_TOP];
  assign unused_addr_bits = ^req_addr[BLOCK_OFFSET-1:0];

  assign accept = (state_q == S_IDLE) && req_valid;
  // The commit edge is the one that moves WAIT into RESP. Both the array update and the read capture happen on it.
  assign commit = (state_q == S_WAIT) && (cnt_q == 4'd0);

  // NOTE: every variable assigned in always_comb gets a default first, so no latch is inferred on unlisted paths.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      S_IDLE: if (req_valid) begin
        state_d = S_WAIT;
        cnt_d   = 4'(LATENCY - 1);
      end
      S_WAIT: if (cnt_q == 4'd0) state_d = S_RESP;
              else               cnt_d   = cnt_q - 4'd1;
      S_RESP: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // NOTE: sequential state is updated only with non-blocking assignments, so every register samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= S_IDLE;
      cnt_q     <= 4'd0;
      write_q   <= 1'b0;
      oor_q     <= 1'b0;
      idx_q     <= '0;
      wdata_q   <= '0;
      rdata_q   <= '0;
      err_q     <= 1'b0;
      written_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (accept) begin
        write_q <= req_write;
        oor_q   <= req_oor;
        idx_q   <= req_idx;
        wdata_q <= req_wdata;
      end
      if (commit) begin
        err_q <= oor_q;
        if (oor_q)        rdata_q <= '0;
        else if (write_q) written_q[idx_q] <= 1'b1;
        else              rdata_q <= written_q[idx_q] ? mem[idx_q] : DEFAULT_DATA;
      end else if (state_q == S_RESP) begin
        err_q <= 1'b0;
      end
    end
  end

  // NOTE: the block array has no reset. The written bits alone decide whether its contents are meaningful.
  always_ff @(posedge clk) begin
    if (commit && write_q && !oor_q) mem[idx_q] <= wdata_q;
  end

  assign mm_ready   = (state_q == S_IDLE);
  assign resp_valid = (state_q == S_RESP);
  assign resp_rdata = rdata_q;
  assign resp_err   = err_q;
  assign state_out  = state_q;

endmodule

// File: tb/tb_main_memory_responder.sv
// Bench for main_memory_responder. A block-level model holds the stored data and the written flags,
// and it covers directed cases, random traffic and a separate LATENCY=1 instance.
module tb_main_memory_responder;

  localparam int          LAT = 4;
  localparam logic [63:0] DEF = 64'hDEADBEEFCAFEBABE;
  localparam int          PER = 10;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid, req_write;
  logic [31:0] req_addr;
  logic [63:0] req_wdata;
  logic        mm_ready, resp_valid, resp_err;
  logic [63:0] resp_rdata;
  logic [1:0]  state_out;

  logic        r1_req_valid, r1_req_write;
  logic [31:0] r1_req_addr;
  logic [63:0] r1_req_wdata;
  logic        r1_mm_ready, r1_resp_valid, r1_resp_err;
  logic [63:0] r1_resp_rdata;
  logic [1:0]  r1_state_out;

  always #(PER/2) clk = ~clk;

  main_memory_responder #(.LATENCY(LAT)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_write(req_write),
    .req_addr(req_addr), .req_wdata(req_wdata), .mm_ready(mm_ready),
    .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_err(resp_err),
    .state_out(state_out));

  main_memory_responder #(.LATENCY(1)) dut1 (
    .clk(clk), .rst(rst), .req_valid(r1_req_valid), .req_write(r1_req_write),
    .req_addr(r1_req_addr), .req_wdata(r1_req_wdata), .mm_ready(r1_mm_ready),
    .resp_valid(r1_resp_valid), .resp_rdata(r1_resp_rdata), .resp_err(r1_resp_err),
    .state_out(r1_state_out));

  // Reference model: block contents, written flags and the value resp_rdata should be holding.
  logic [63:0] m_data [256];
  bit          m_wr   [256];
  logic [63:0] exp_rdata;

  int  errors = 0;
  int  checks = 0;
  time last_accept = 0;
  time prev_accept = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // The caller enters at a negedge with the DUT idle. With hold set, random junk is presented during the busy window,
  // and req_valid is still high on return.
  task automatic do_req(input string tag, input logic wr, input logic [31:0] addr,
                        input logic [63:0] wd, input bit hold);
    int   n;
    bit   seen;
    logic oor;
    int   idx;
    check({tag, "/ready_before"}, 64'(mm_ready), 64'd1);
    req_valid = 1'b1; req_write = wr; req_addr = addr; req_wdata = wd;
    @(posedge clk);
    prev_accept = last_accept;
    last_accept = $time;
    @(negedge clk);
    check({tag, "/ready_busy"}, 64'(mm_ready), 64'd0);
    check({tag, "/state_wait"}, 64'(state_out), 64'd1);
    oor = (addr[31:14] != 18'd0);
    idx = int'(addr[13:6]);
    if (oor) exp_rdata = 64'd0;
    else if (wr) begin m_data[idx] = wd; m_wr[idx] = 1'b1; end
    else exp_rdata = m_wr[idx] ? m_data[idx] : DEF;
    if (!hold) req_valid = 1'b0;
    n = 1; seen = 1'b0;
    while (!seen && n <= 20) begin
      if (resp_valid === 1'b1) seen = 1'b1;
      else begin
        if (hold) begin
          req_valid = 1'b1;
          req_write = 1'($urandom_range(0, 1));
          req_addr  = {18'd0, 8'($urandom_range(0, 255)), 6'd0};
          req_wdata = {$urandom, $urandom};
        end
        @(negedge clk);
        n++;
      end
    end
    check({tag, "/resp_latency"}, 64'(n), 64'(LAT + 1));
    check({tag, "/resp_err"}, 64'(resp_err), 64'(oor));
    check({tag, "/resp_rdata"}, resp_rdata, exp_rdata);
    check({tag, "/state_resp"}, 64'(state_out), 64'd2);
    check({tag, "/ready_resp"}, 64'(mm_ready), 64'd0);
    @(negedge clk);
    check({tag, "/pulse_end"}, 64'(resp_valid), 64'd0);
    check({tag, "/ready_after"}, 64'(mm_ready), 64'd1);
    check({tag, "/err_clear"}, 64'(resp_err), 64'd0);
    check({tag, "/rdata_hold"}, resp_rdata, exp_rdata);
  endtask

  initial begin
    #(200000);
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic        wr;
    logic [7:0]  idx;
    logic [17:0] upper;
    logic [63:0] wd;
    logic [63:0] r1_wd;
    time         r1_last;
    int          stray;

    for (int i = 0; i < 256; i++) begin m_data[i] = '0; m_wr[i] = 1'b0; end
    exp_rdata = 64'd0;
    rst = 1'b1;
    req_valid = 1'b0; req_write = 1'b0; req_addr = '0; req_wdata = '0;
    r1_req_valid = 1'b0; r1_req_write = 1'b0; r1_req_addr = '0; r1_req_wdata = '0;
    #1;
    check("rst/mm_ready", 64'(mm_ready), 64'd1);
    check("rst/resp_valid", 64'(resp_valid), 64'd0);
    check("rst/resp_rdata", resp_rdata, 64'd0);
    check("rst/resp_err", 64'(resp_err), 64'd0);
    check("rst/state_out", 64'(state_out), 64'd0);
    @(negedge clk); @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    // First read of an unwritten block.
    do_req("t1_read40", 1'b0, 32'h0000_0040, 64'd0, 1'b0);
    // Write a block, then read it back.
    do_req("t2_write80", 1'b1, 32'h0000_0080, 64'h0123_4567_89AB_CDEF, 1'b0);
    do_req("t2_read80", 1'b0, 32'h0000_0080, 64'd0, 1'b0);
    // An out-of-range read, then a read of block 0, which must not alias.
    do_req("t3_oor", 1'b0, 32'h0010_0000, 64'd0, 1'b0);
    do_req("t3_read0", 1'b0, 32'h0000_0000, 64'd0, 1'b0);
    // Requests held high while busy are ignored. The next accept lands exactly LAT+2 cycles later.
    do_req("t4_first", 1'b0, 32'h0000_0080, 64'd0, 1'b1);
    do_req("t4_second", 1'b0, 32'h0000_0140, 64'd0, 1'b0);
    check("t4/spacing", 64'(last_accept - prev_accept), 64'((LAT + 2) * PER));

    // Reset during the WAIT of a write drops the request.
    req_valid = 1'b1; req_write = 1'b1; req_addr = 32'h0000_00C0; req_wdata = 64'h1111_2222_3333_4444;
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    #1;
    check("t5/rst_ready", 64'(mm_ready), 64'd1);
    check("t5/rst_resp_valid", 64'(resp_valid), 64'd0);
    check("t5/rst_state", 64'(state_out), 64'd0);
    check("t5/rst_rdata", resp_rdata, 64'd0);
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 256; i++) m_wr[i] = 1'b0;
    exp_rdata = 64'd0;
    stray = 0;
    for (int i = 0; i < 8; i++) begin
      if (resp_valid !== 1'b0) stray++;
      @(negedge clk);
    end
    check("t5/no_stray_resp", 64'(stray), 64'd0);
    do_req("t5_readC0", 1'b0, 32'h0000_00C0, 64'd0, 1'b0);
    do_req("t5_read80", 1'b0, 32'h0000_0080, 64'd0, 1'b0);

    // Random traffic over a small set of blocks, with occasional out-of-range addresses.
    for (int k = 0; k < 40; k++) begin
      wr    = 1'($urandom_range(0, 1));
      idx   = 8'($urandom_range(0, 7));
      upper = ($urandom_range(0, 7) == 0) ? 18'($urandom_range(1, 262143)) : 18'd0;
      wd    = {$urandom, $urandom};
      do_req($sformatf("rnd%0d", k), wr, {upper, idx, 6'($urandom_range(0, 63))}, wd, 1'b0);
    end

    // LATENCY=1 instance: back-to-back write and read with req_valid held continuously.
    check("t6/ready_idle", 64'(r1_mm_ready), 64'd1);
    r1_wd = 64'd0;
    r1_last = 0;
    for (int k = 0; k < 6; k++) begin
      check($sformatf("t6_%0d/ready", k), 64'(r1_mm_ready), 64'd1);
      check($sformatf("t6_%0d/no_resp", k), 64'(r1_resp_valid), 64'd0);
      r1_req_valid = 1'b1;
      r1_req_addr  = {18'd0, 8'(20 + k / 2), 6'd0};
      if (k % 2 == 0) begin
        r1_wd = {$urandom, $urandom};
        r1_req_write = 1'b1;
        r1_req_wdata = r1_wd;
      end else begin
        r1_req_write = 1'b0;
        r1_req_wdata = ~r1_wd;
      end
      @(posedge clk);
      @(negedge clk);
      check($sformatf("t6_%0d/busy", k), 64'(r1_mm_ready), 64'd0);
      @(negedge clk);
      check($sformatf("t6_%0d/resp", k), 64'(r1_resp_valid), 64'd1);
      check($sformatf("t6_%0d/err", k), 64'(r1_resp_err), 64'd0);
      if (k % 2 == 1) check($sformatf("t6_%0d/rdata", k), r1_resp_rdata, r1_wd);
      if (k > 0) check($sformatf("t6_%0d/period", k), 64'($time - r1_last), 64'(3 * PER));
      r1_last = $time;
      @(negedge clk);
    end
    r1_req_valid = 1'b0;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
